mod1_0: RTL and testbench

MOD1_0 -- requirements
Module: mod1_0

---
 rtl/mod1_0.sv | 59 +++++
 tb/tb_mod1_0.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mod1_0.sv
// mod1_0: radix-2 stage-1 butterfly over 16-lane blocks; first half of each
// block is buffered as a operands, second half supplies b and yields a+b, a-b.
module mod1_0 #(
   parameter int DIN_W = 11,
   parameter int NUM   = 16,
   parameter int HALF  = 8
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              valid_mod1,
   input  logic signed [NUM-1:0][DIN_W-1:0]  din_R,
   input  logic signed [NUM-1:0][DIN_W-1:0]  din_Q,
   output logic signed [NUM-1:0][DIN_W:0]    dout_R_add10,
   output logic signed [NUM-1:0][DIN_W:0]    dout_Q_add10,
   output logic signed [NUM-1:0][DIN_W:0]    dout_R_sub10,
   output logic signed [NUM-1:0][DIN_W:0]    dout_Q_sub10,
   output logic                              alert_mod11
);
   localparam int W  = DIN_W + 1;
   localparam int AW = $clog2(HALF);
   logic [3:0] cnt;
   logic second, hit;
   logic [AW-1:0] idx;
   logic [NUM-1:0][DIN_W-1:0] buf_r [HALF];
   logic [NUM-1:0][DIN_W-1:0] buf_q [HALF];
   logic [NUM-1:0][W-1:0] add_r, sub_r, add_q, sub_q;
   assign second = cnt >= 4'(HALF);
   assign hit    = valid_mod1 && second;
   assign idx    = second ? AW'(cnt - 4'(HALF)) : AW'(cnt);
   // write and read halves never overlap, so the buffer needs no bypass or reset
   always_ff @(posedge clk)
      if (rstn && valid_mod1 && !second) begin
         buf_r[idx] <= din_R;
         buf_q[idx] <= din_Q;
      end
   always_comb
      for (int k = 0; k < NUM; k++) begin
         add_r[k] = W'($signed(buf_r[idx][k])) + W'($signed(din_R[k]));
         sub_r[k] = W'($signed(buf_r[idx][k])) - W'($signed(din_R[k]));
         add_q[k] = W'($signed(buf_q[idx][k])) + W'($signed(din_Q[k]));
         sub_q[k] = W'($signed(buf_q[idx][k])) - W'($signed(din_Q[k]));
      end
   always_ff @(posedge clk)
      if (!rstn) begin
         cnt          <= '0;
         alert_mod11  <= 1'b0;
         dout_R_add10 <= '0;
         dout_R_sub10 <= '0;
         dout_Q_add10 <= '0;
         dout_Q_sub10 <= '0;
      end else begin
         if (valid_mod1) cnt <= cnt + 4'd1;
         alert_mod11  <= hit;
         dout_R_add10 <= hit ? add_r : '0;
         dout_R_sub10 <= hit ? sub_r : '0;
         dout_Q_add10 <= hit ? add_q : '0;
         dout_Q_sub10 <= hit ? sub_q : '0;
      end
endmodule

// File: tb/tb_mod1_0.sv
// tb_mod1_0: directed checks of the mod1_0 butterfly, sampled 1 time unit after each edge.
module tb_mod1_0;
   localparam int DIN_W = 11;
   localparam int NUM   = 16;
   localparam int W     = DIN_W + 1;
   typedef logic [NUM-1:0][W-1:0] vec_t;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic valid_mod1 = 1'b0;
   logic [NUM-1:0][DIN_W-1:0] din_R = '0, din_Q = '0;
   logic [NUM-1:0][W-1:0] dout_R_add10, dout_Q_add10, dout_R_sub10, dout_Q_sub10;
   logic alert_mod11;
   int checks = 0;
   int errors = 0;

   mod1_0 #(.DIN_W(DIN_W), .NUM(NUM), .HALF(8)) dut (
      .clk(clk), .rstn(rstn), .valid_mod1(valid_mod1),
      .din_R(din_R), .din_Q(din_Q),
      .dout_R_add10(dout_R_add10), .dout_Q_add10(dout_Q_add10),
      .dout_R_sub10(dout_R_sub10), .dout_Q_sub10(dout_Q_sub10),
      .alert_mod11(alert_mod11));

   always #5 clk = ~clk;

   task automatic step(input bit v, input bit rn);
      valid_mod1 = v;
      rstn = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_din();
      for (int k = 0; k < NUM; k++) begin
         din_R[k] = DIN_W'($urandom);
         din_Q[k] = DIN_W'($urandom);
      end
   endtask

   task automatic check(input string tag, input bit ea, input vec_t ear, input vec_t esr,
                        input vec_t eaq, input vec_t esq);
      checks++;
      assert (alert_mod11 === ea && dout_R_add10 === ear && dout_R_sub10 === esr &&
              dout_Q_add10 === eaq && dout_Q_sub10 === esq)
      else begin
         errors++;
         $error("FAIL %s alert=%0b/%0b radd=%h/%h rsub=%h/%h qadd=%h/%h qsub=%h/%h", tag,
                alert_mod11, ea, dout_R_add10, ear, dout_R_sub10, esr,
                dout_Q_add10, eaq, dout_Q_sub10, esq);
      end
   endtask

   // stimulus value for block cycle c, lane k, component q (0=R, 1=Q)
   function automatic int val(input int mode, input int c, input int k, input bit q);
      case (mode)
         0: return c < 8 ? (q ? -(8 * c + k) : 8 * c + k) : 1;
         1: return c == 0 ? (q ? -1024 : 1023) :
                   c == 1 ? -1024 :
                   c == 8 ? 1023 :
                   c == 9 ? (q ? -1024 : 1023) : 0;
         2: return c < 8 ? (q ? c - k : 10 * c + k) : (q ? k : c - 8);
         default: return int'($urandom_range(0, 2047)) - 1024;
      endcase
   endfunction

   task automatic run_block(input int mode, input string tag, input int gap_c);
      int ar [8][NUM];
      int aq [8][NUM];
      int r, q;
      vec_t e1, e2, e3, e4;
      for (int c = 0; c < 16; c++) begin
         e1 = '0; e2 = '0; e3 = '0; e4 = '0;
         for (int k = 0; k < NUM; k++) begin
            r = val(mode, c, k, 1'b0);
            q = val(mode, c, k, 1'b1);
            din_R[k] = DIN_W'(r);
            din_Q[k] = DIN_W'(q);
            if (c < 8) begin
               ar[c][k] = r;
               aq[c][k] = q;
            end else begin
               e1[k] = W'(ar[c-8][k] + r);
               e2[k] = W'(ar[c-8][k] - r);
               e3[k] = W'(aq[c-8][k] + q);
               e4[k] = W'(aq[c-8][k] - q);
            end
         end
         step(1'b1, 1'b1);
         check(tag, c >= 8, e1, e2, e3, e4);
         if (c == gap_c)
            for (int g = 0; g < 3; g++) begin
               randomize_din();
               step(1'b0, 1'b1);
               check("gap", 1'b0, '0, '0, '0, '0);
            end
      end
   endtask

   initial begin
      // reset held with valid high and random data
      for (int i = 0; i < 3; i++) begin
         randomize_din();
         step(1'b1, 1'b0);
         check("reset", 1'b0, '0, '0, '0, '0);
      end
      run_block(0, "ramp", -1);
      run_block(1, "extremes", -1);
      run_block(2, "valid_gap", 10);
      // partial block, then reset at cnt=5
      for (int c = 0; c < 5; c++) begin
         randomize_din();
         step(1'b1, 1'b1);
         check("partial", 1'b0, '0, '0, '0, '0);
      end
      for (int i = 0; i < 2; i++) begin
         randomize_din();
         step(1'b1, 1'b0);
         check("mid_reset", 1'b0, '0, '0, '0, '0);
      end
      run_block(2, "after_reset", -1);
      // two frames back-to-back: four contiguous blocks
      for (int b = 0; b < 4; b++) run_block(3, "b2b", -1);
      valid_mod1 = 1'b0;
      step(1'b0, 1'b1);
      check("idle", 1'b0, '0, '0, '0, '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
